// File: rtl/wb_grf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_grf_pkg
// Description : Shared opcode/funct constants, write-back source and
//               destination select enums, and the destination field helper.
//               These constants are also used by the D/E/M decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_grf_pkg;

    // Primary opcodes, cmd[31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_COP0  = 6'b010000;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes, cmd[5:0]
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_JALR  = 6'b001001;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLTU  = 6'b101011;

    // COP0 sub-op in the rs field, cmd[25:21]
    localparam logic [4:0] c_CP0_MF   = 5'b00000;
    localparam logic [4:0] c_CP0_MT   = 5'b00100;
    localparam logic [4:0] c_CP0_CO   = 5'b10000;

    localparam logic [4:0] c_REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_DM   = 3'd2,
        WB_HI   = 3'd3,
        WB_LO   = 3'd4,
        WB_CP0  = 3'd5,
        WB_LINK = 3'd6
    } wb_src_e;

    typedef enum logic [1:0] {
        RD  = 2'd0,
        RT  = 2'd1,
        R31 = 2'd2
    } dst_sel_e;

    // Extracts the destination register index selected by the decoder
    function automatic logic [4:0] dest_index(input dst_sel_e sel, input logic [31:0] cmd);
        logic [4:0] idx;
        idx = 5'd0;
        case (sel)
            RD:      idx = cmd[15:11];
            RT:      idx = cmd[20:16];
            R31:     idx = c_REG_RA;
            default: idx = 5'd0;
        endcase
        return idx;
    endfunction

endpackage : wb_grf_pkg
`default_nettype wire

// File: rtl/wb_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_decode
// Description : Combinational W-stage decoder. Maps the instruction word to a
//               register-write enable, destination index and write-back
//               source select. Writes aimed at $0 are reported as no write.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_decode
    import wb_grf_pkg::*;
(
    input  logic [31:0] i_cmd,
    output logic        o_regwrite,
    output logic [4:0]  o_dest,
    output wb_src_e     o_src
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    wb_src_e    w_src;
    dst_sel_e   w_dsel;
    logic [4:0] w_dest;
    logic       w_unused;

    assign w_op     = i_cmd[31:26];
    assign w_funct  = i_cmd[5:0];
    assign w_rs     = i_cmd[25:21];
    // The shamt field never affects write-back
    assign w_unused = ^i_cmd[10:6];

    // Opcode/funct decode to source and destination selects
    always_comb begin
        w_src  = WB_NONE;
        w_dsel = RD;
        case (w_op)
            c_OP_RTYPE: begin
                w_dsel = RD;
                case (w_funct)
                    c_FN_ADD, c_FN_SUB, c_FN_AND,
                    c_FN_OR,  c_FN_SLT, c_FN_SLTU: w_src = WB_ALU;
                    c_FN_MFHI:                     w_src = WB_HI;
                    c_FN_MFLO:                     w_src = WB_LO;
                    c_FN_JALR:                     w_src = WB_LINK;
                    default:                       w_src = WB_NONE;
                endcase
            end
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: begin
                w_src  = WB_ALU;
                w_dsel = RT;
            end
            c_OP_LW, c_OP_LH, c_OP_LB: begin
                w_src  = WB_DM;
                w_dsel = RT;
            end
            c_OP_COP0: begin
                // Only mfc0 writes; mtc0 and eret share this opcode
                w_dsel = RT;
                if (w_rs == c_CP0_MF) begin
                    w_src = WB_CP0;
                end
            end
            c_OP_JAL: begin
                w_src  = WB_LINK;
                w_dsel = R31;
            end
            default: begin
                w_src  = WB_NONE;
                w_dsel = RD;
            end
        endcase
    end

    assign w_dest     = dest_index(w_dsel, i_cmd);
    assign o_regwrite = (w_src != WB_NONE) && (w_dest != 5'd0);
    assign o_dest     = w_dest;
    assign o_src      = w_src;

endmodule : wb_decode
`default_nettype wire

// File: rtl/wb_grf.sv
`default_nettype none
// ============================================================================
// Module      : wb_grf
// Description : Write-back stage and 32x32 general register file. Selects the
//               write-back value, writes the array, serves two D-stage read
//               ports with same-cycle bypass, exports the write triple for
//               forwarding and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int          NREG      = 32,
    parameter int          LINK_OFS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] W_command,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_DM_out,
    input  logic [31:0] W_ALU_result,
    input  logic [31:0] W_HI,
    input  logic [31:0] W_LO,
    input  logic [31:0] W_CP0_out,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        W_regwrite,
    output logic [4:0]  W_waddr,
    output logic [31:0] W_wdata,
    output logic [31:0] retired_cnt
);

    logic [31:0] r_grf [NREG];
    logic [31:0] r_retired_cnt;

    logic        w_dec_we;
    logic [4:0]  w_dec_dest;
    wb_src_e     w_dec_src;
    logic [31:0] w_link;
    logic [31:0] w_src_val;
    logic        w_regwrite;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;

    wb_decode u_decode (
        .i_cmd      (W_command),
        .o_regwrite (w_dec_we),
        .o_dest     (w_dec_dest),
        .o_src      (w_dec_src)
    );

    // Link value wraps modulo 2^32
    assign w_link = W_PC + 32'(LINK_OFS);

    // Write-back source multiplexer
    always_comb begin
        w_src_val = 32'd0;
        case (w_dec_src)
            WB_ALU:  w_src_val = W_ALU_result;
            WB_DM:   w_src_val = W_DM_out;
            WB_HI:   w_src_val = W_HI;
            WB_LO:   w_src_val = W_LO;
            WB_CP0:  w_src_val = W_CP0_out;
            WB_LINK: w_src_val = w_link;
            default: w_src_val = 32'd0;
        endcase
    end

    // Write triple is zeroed whenever nothing is written so forwarding never
    // sees a stale destination
    assign w_regwrite = w_dec_we;
    assign w_waddr    = w_dec_we ? w_dec_dest : 5'd0;
    assign w_wdata    = w_dec_we ? w_src_val  : 32'd0;

    // Register array: async clear, one-cycle write latency
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= RESET_VAL;
            end
        end else if (w_regwrite) begin
            r_grf[w_waddr] <= w_wdata;
        end
    end

    // Retired-instruction counter, bubbles excluded, wraps naturally
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_retired_cnt <= 32'd0;
        end else if (W_command != 32'd0) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    // Read port 1: $0 hardwired, then same-cycle bypass, then array
    always_comb begin
        w_rs_data = r_grf[D_rs_addr];
        if (D_rs_addr == 5'd0) begin
            w_rs_data = 32'd0;
        end else if (w_regwrite && (D_rs_addr == w_waddr)) begin
            w_rs_data = w_wdata;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        w_rt_data = r_grf[D_rt_addr];
        if (D_rt_addr == 5'd0) begin
            w_rt_data = 32'd0;
        end else if (w_regwrite && (D_rt_addr == w_waddr)) begin
            w_rt_data = w_wdata;
        end
    end

    assign D_rs_data   = w_rs_data;
    assign D_rt_data   = w_rt_data;
    assign W_regwrite  = w_regwrite;
    assign W_waddr     = w_waddr;
    assign W_wdata     = w_wdata;
    assign retired_cnt = r_retired_cnt;

endmodule : wb_grf
`default_nettype wire

// File: tb/tb_wb_grf.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_grf
// Description : Self-checking bench for wb_grf. Directed scenarios plus
//               randomized instruction streams against a mnemonic-level
//               register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_grf;

    logic        clk;
    logic        res;
    logic [31:0] W_command;
    logic [31:0] W_PC;
    logic [31:0] W_DM_out;
    logic [31:0] W_ALU_result;
    logic [31:0] W_HI;
    logic [31:0] W_LO;
    logic [31:0] W_CP0_out;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        W_regwrite;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;
    logic [31:0] retired_cnt;

    wb_grf dut (
        .clk          (clk),
        .res          (res),
        .W_command    (W_command),
        .W_PC         (W_PC),
        .W_DM_out     (W_DM_out),
        .W_ALU_result (W_ALU_result),
        .W_HI         (W_HI),
        .W_LO         (W_LO),
        .W_CP0_out    (W_CP0_out),
        .D_rs_addr    (D_rs_addr),
        .D_rt_addr    (D_rt_addr),
        .D_rs_data    (D_rs_data),
        .D_rt_data    (D_rt_data),
        .W_regwrite   (W_regwrite),
        .W_waddr      (W_waddr),
        .W_wdata      (W_wdata),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_reg [32];
    logic [31:0] m_cnt;
    logic        exp_we;
    logic [4:0]  exp_dst;
    logic [31:0] exp_val;

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)                 return 32'd0;
        if (exp_we && a == exp_dst)    return exp_val;
        return m_reg[a];
    endfunction

    task automatic set_exp(input logic we, input logic [4:0] d, input logic [31:0] v);
        exp_we  = we && (d != 5'd0);
        exp_dst = exp_we ? d : 5'd0;
        exp_val = exp_we ? v : 32'd0;
    endtask

    // Drive a raw instruction word with the write the spec says it makes
    task automatic drive(input logic [31:0] cmd, input logic we, input logic [4:0] d, input logic [31:0] v);
        W_command = cmd;
        set_exp(we, d, v);
    endtask

    // Build an instruction from a mnemonic index; the expected write follows
    // directly from what kind of instruction was assembled
    task automatic make_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm);
        logic [31:0] c;
        logic        we;
        logic [4:0]  d;
        logic [31:0] v;
        c = 32'd0; we = 1'b0; d = 5'd0; v = 32'd0;
        case (kind)
            0:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h20}; we = 1; d = rd; v = W_ALU_result; end // add
            1:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h22}; we = 1; d = rd; v = W_ALU_result; end // sub
            2:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h24}; we = 1; d = rd; v = W_ALU_result; end // and
            3:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h25}; we = 1; d = rd; v = W_ALU_result; end // or
            4:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h2a}; we = 1; d = rd; v = W_ALU_result; end // slt
            5:  begin c = {6'h00, rs, rt, rd, 5'd0, 6'h2b}; we = 1; d = rd; v = W_ALU_result; end // sltu
            6:  begin c = {6'h00, 10'd0, rd, 5'd0, 6'h10}; we = 1; d = rd; v = W_HI; end           // mfhi
            7:  begin c = {6'h00, 10'd0, rd, 5'd0, 6'h12}; we = 1; d = rd; v = W_LO; end           // mflo
            8:  begin c = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09}; we = 1; d = rd; v = W_PC + 32'd8; end // jalr
            9:  begin c = {6'h08, rs, rt, imm}; we = 1; d = rt; v = W_ALU_result; end              // addi
            10: begin c = {6'h0c, rs, rt, imm}; we = 1; d = rt; v = W_ALU_result; end              // andi
            11: begin c = {6'h0d, rs, rt, imm}; we = 1; d = rt; v = W_ALU_result; end              // ori
            12: begin c = {6'h0f, 5'd0, rt, imm}; we = 1; d = rt; v = W_ALU_result; end            // lui
            13: begin c = {6'h23, rs, rt, imm}; we = 1; d = rt; v = W_DM_out; end                  // lw
            14: begin c = {6'h21, rs, rt, imm}; we = 1; d = rt; v = W_DM_out; end                  // lh
            15: begin c = {6'h20, rs, rt, imm}; we = 1; d = rt; v = W_DM_out; end                  // lb
            16: begin c = {6'h10, 5'd0, rt, rd, 11'd0}; we = 1; d = rt; v = W_CP0_out; end        // mfc0
            17: begin c = {6'h03, 10'd0, imm}; we = 1; d = 5'd31; v = W_PC + 32'd8; end           // jal
            18: c = {6'h2b, rs, rt, imm};                 // sw
            19: c = {6'h04, rs, rt, imm};                 // beq
            20: c = {6'h02, 10'd0, imm};                  // j
            21: c = {6'h00, rs, 15'd0, 6'h08};            // jr
            22: c = {6'h00, rs, rt, 10'd0, 6'h18};        // mult
            23: c = {6'h00, rs, 15'd0, 6'h11};            // mthi
            24: c = {6'h10, 5'h04, rt, rd, 11'd0};        // mtc0
            25: c = 32'h4200_0018;                        // eret
            26: c = 32'd0;                                // bubble
            27: c = {6'h3f, rs, rt, imm};                 // unknown opcode
            default: c = {6'h00, rs, rt, rd, 5'd0, 6'h3f}; // unknown funct
        endcase
        drive(c, we, d, v);
    endtask

    // Check every output at negedge+1, then advance the model at posedge
    task automatic cycle();
        #1;
        check("regwrite", {31'd0, W_regwrite}, {31'd0, exp_we});
        check("waddr",    {27'd0, W_waddr},    {27'd0, exp_dst});
        check("wdata",    W_wdata,             exp_val);
        check("rs_data",  D_rs_data,           model_read(D_rs_addr));
        check("rt_data",  D_rt_data,           model_read(D_rt_addr));
        check("retired",  retired_cnt,         m_cnt);
        @(posedge clk);
        if (!res) begin
            if (exp_we) m_reg[exp_dst] = exp_val;
            if (W_command != 32'd0) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic bubble();
        drive(32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    logic [4:0]  f_rs, f_rt, f_rd;
    logic [15:0] f_imm;

    initial begin
        n_chk = 0; n_pass = 0;
        res = 1'b1;
        W_command = 32'd0; W_PC = 32'd0; W_DM_out = 32'd0; W_ALU_result = 32'd0;
        W_HI = 32'd0; W_LO = 32'd0; W_CP0_out = 32'd0;
        D_rs_addr = 5'd5; D_rt_addr = 5'd31;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_cnt = 32'd0;
        set_exp(1'b0, 5'd0, 32'd0);

        // Reset state
        @(negedge clk);
        cycle();
        res = 1'b0;

        // ori $8,$0,0x1234: bypass same cycle, array next cycle
        W_ALU_result = 32'h0000_1234;
        D_rt_addr = 5'd8; D_rs_addr = 5'd0;
        drive(32'h3408_1234, 1'b1, 5'd8, 32'h0000_1234);
        cycle();
        W_ALU_result = 32'hFFFF_0000;
        bubble();
        cycle();

        // jal and jalr $0
        W_PC = 32'h0000_3010;
        D_rs_addr = 5'd31; D_rt_addr = 5'd31;
        drive(32'h0C00_0C10, 1'b1, 5'd31, 32'h0000_3018);
        cycle();
        D_rs_addr = 5'd0; D_rt_addr = 5'd31;
        drive(32'h0000_0009, 1'b0, 5'd0, 32'd0);
        cycle();

        // Link wrap at top of address space
        W_PC = 32'hFFFF_FFFC;
        drive(32'h0C00_0000, 1'b1, 5'd31, 32'h0000_0004);
        cycle();

        // mfhi $3 then mflo $3
        W_HI = 32'hDEAD_BEEF; W_LO = 32'h0000_0001;
        D_rs_addr = 5'd3; D_rt_addr = 5'd3;
        drive(32'h0000_1810, 1'b1, 5'd3, 32'hDEAD_BEEF);
        cycle();
        drive(32'h0000_1812, 1'b1, 5'd3, 32'h0000_0001);
        cycle();
        bubble();
        cycle();

        // mfc0 $9,$12 then sw: no write but still retires
        W_CP0_out = 32'h0000_FC01;
        D_rs_addr = 5'd9; D_rt_addr = 5'd3;
        drive(32'h4009_6000, 1'b1, 5'd9, 32'h0000_FC01);
        cycle();
        drive(32'hAC09_0000, 1'b0, 5'd0, 32'd0);
        cycle();

        // Bubble stream
        for (int i = 0; i < 10; i++) begin
            bubble();
            D_rs_addr = 5'($urandom); D_rt_addr = 5'($urandom);
            cycle();
        end

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            W_ALU_result = $urandom; W_DM_out = $urandom; W_HI = $urandom;
            W_LO = $urandom; W_CP0_out = $urandom;
            W_PC = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            f_rs = 5'($urandom); f_rt = 5'($urandom); f_rd = 5'($urandom);
            f_imm = 16'($urandom);
            if ($urandom_range(0, 9) == 0) f_rd = 5'd0;
            if ($urandom_range(0, 9) == 0) f_rt = 5'd0;
            make_instr(int'($urandom_range(0, 28)), f_rs, f_rt, f_rd, f_imm);
            D_rs_addr = 5'($urandom); D_rt_addr = 5'($urandom);
            if (exp_we && $urandom_range(0, 3) == 0) begin
                D_rs_addr = exp_dst; D_rt_addr = exp_dst;
            end
            cycle();
        end

        // Asynchronous reset mid-run clears the array immediately
        W_ALU_result = 32'h0000_0055;
        D_rs_addr = 5'd5; D_rt_addr = 5'd5;
        drive({6'h0d, 5'd0, 5'd5, 16'h0055}, 1'b1, 5'd5, 32'h0000_0055);
        cycle();
        bubble();
        #1;
        check("pre_rst_r5", D_rs_data, model_read(5'd5));
        #2;
        res = 1'b1;
        #1;
        check("rst_r5_rs", D_rs_data, 32'd0);
        check("rst_r5_rt", D_rt_data, 32'd0);
        check("rst_cnt",   retired_cnt, 32'd0);
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_cnt = 32'd0;
        @(negedge clk);
        res = 1'b0;
        cycle();

        // Counter wrap: preload near the top, then retire across the boundary
        force dut.r_retired_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_retired_cnt;
        m_cnt = 32'hFFFF_FFFE;
        W_ALU_result = 32'h0000_00AA;
        D_rs_addr = 5'd7; D_rt_addr = 5'd0;
        drive({6'h0d, 5'd0, 5'd7, 16'h00AA}, 1'b1, 5'd7, 32'h0000_00AA);
        cycle();
        drive(32'hAC07_0000, 1'b0, 5'd0, 32'd0);
        cycle();
        drive(32'hAC07_0000, 1'b0, 5'd0, 32'd0);
        cycle();
        bubble();
        cycle();
        check("cnt_wrapped", retired_cnt, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_wb_grf
`default_nettype wire
